// File: rtl/ahb_sram_ws.sv
// AHB-Lite SRAM slave with byte-lane writes, programmable wait states and a
// two-cycle ERROR response. Outputs are registered from the FSM. A read issued
// right behind a write to the same word sees the freshly merged data.
module ahb_sram_ws #(
    parameter int    ADDR_WIDTH  = 19,
    parameter int    DATA_WIDTH  = 32,
    parameter int    MEM_BYTES   = 2**ADDR_WIDTH,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           haddr_i,
    input  logic [DATA_WIDTH-1:0] hwdata_i,
    output logic [DATA_WIDTH-1:0] hrdata_o,
    input  logic                  hwrite_i,
    input  logic [2:0]            hsize_i,
    input  logic [1:0]            htrans_i,
    input  logic                  hsel_i,
    input  logic                  hready_in_i,
    output logic                  hready_o,
    output logic                  hresp_o
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(NBYTES);
    localparam int DEPTH  = MEM_BYTES / NBYTES;
    localparam int IDXW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] off_q;
    logic                  wr_q;
    logic [2:0]            size_q;
    logic [3:0]            cnt_q;
    logic                  hready_q;
    logic                  hresp_q;
    logic [DATA_WIDTH-1:0] hrdata_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept_s;
    logic                  err_s;
    logic                  do_write_s;
    logic [IDXW-1:0]       new_idx_s;
    logic [IDXW-1:0]       cur_idx_s;
    logic [IDXW-1:0]       rd_idx_s;
    logic [NBYTES-1:0]     be_s;
    logic [DATA_WIDTH-1:0] old_word_s;
    logic [DATA_WIDTH-1:0] wmerge_s;
    logic [DATA_WIDTH-1:0] rd_word_s;
    logic                  unused_s;

    // Lane b is written when it falls inside the 2**size byte block holding lo.
    function automatic logic [NBYTES-1:0] lane_en(input logic [2:0] size, input logic [LSB-1:0] lo);
        logic [NBYTES-1:0] en;
        en = '0;
        for (int b = 0; b < NBYTES; b++) begin
            en[b] = ((b >> size) == (int'(lo) >> size));
        end
        return en;
    endfunction

    // True when the low address bits are not a multiple of the transfer size.
    function automatic logic misaligned(input logic [2:0] size, input logic [2:0] lo);
        logic m;
        case (size)
            3'd0:    m = 1'b0;
            3'd1:    m = lo[0];
            3'd2:    m = |lo[1:0];
            default: m = |lo;
        endcase
        return m;
    endfunction

    assign unused_s = ^{haddr_i[31:ADDR_WIDTH], htrans_i[0], off_q};

    // Address-phase decode, byte-lane merge and same-word read forwarding.
    always_comb begin
        accept_s   = hsel_i & htrans_i[1] & hready_in_i &
                     ((state_q == ST_IDLE) | (state_q == ST_DATA) | (state_q == ST_ERR2));
        err_s      = (hsize_i > 3'(LSB)) |
                     misaligned(hsize_i, haddr_i[2:0]) |
                     ({1'b0, haddr_i[ADDR_WIDTH-1:0]} >= (ADDR_WIDTH+1)'(MEM_BYTES));
        new_idx_s  = haddr_i[LSB +: IDXW];
        cur_idx_s  = off_q[LSB +: IDXW];
        do_write_s = (state_q == ST_DATA) & wr_q;
        be_s       = lane_en(size_q, off_q[LSB-1:0]);
        old_word_s = mem[cur_idx_s];
        wmerge_s   = old_word_s;
        for (int b = 0; b < NBYTES; b++) begin
            if (be_s[b]) begin
                wmerge_s[8*b +: 8] = hwdata_i[8*b +: 8];
            end else begin
                wmerge_s[8*b +: 8] = old_word_s[8*b +: 8];
            end
        end
        if (state_q == ST_WAIT) begin
            rd_idx_s = cur_idx_s;
        end else begin
            rd_idx_s = new_idx_s;
        end
        if (do_write_s && (rd_idx_s == cur_idx_s)) begin
            rd_word_s = wmerge_s;
        end else begin
            rd_word_s = mem[rd_idx_s];
        end
    end

    // Memory array write at the end of a write data phase; contents survive reset.
    always_ff @(posedge clk) begin
        if (do_write_s) begin
            mem[cur_idx_s] <= wmerge_s;
        end
    end

    // Transfer FSM with registered HREADYOUT, HRESP and HRDATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            off_q    <= '0;
            wr_q     <= 1'b0;
            size_q   <= 3'd0;
            cnt_q    <= 4'd0;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
            hrdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    if (accept_s) begin
                        off_q  <= haddr_i[ADDR_WIDTH-1:0];
                        wr_q   <= hwrite_i;
                        size_q <= hsize_i;
                        if (err_s) begin
                            state_q  <= ST_ERR1;
                            hready_q <= 1'b0;
                            hresp_q  <= 1'b1;
                            hrdata_q <= '0;
                        end else if (WAIT_STATES > 0) begin
                            state_q  <= ST_WAIT;
                            cnt_q    <= 4'(WAIT_STATES - 1);
                            hready_q <= 1'b0;
                            hresp_q  <= 1'b0;
                            hrdata_q <= '0;
                        end else begin
                            state_q  <= ST_DATA;
                            hready_q <= 1'b1;
                            hresp_q  <= 1'b0;
                            hrdata_q <= rd_word_s;
                        end
                    end else begin
                        state_q  <= ST_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= 1'b0;
                        hrdata_q <= '0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q  <= ST_DATA;
                        hready_q <= 1'b1;
                        hresp_q  <= 1'b0;
                        hrdata_q <= rd_word_s;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state_q  <= ST_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= 1'b1;
                    hrdata_q <= '0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= 1'b0;
                    hrdata_q <= '0;
                end
            endcase
        end
    end

    assign hready_o = hready_q;
    assign hresp_o  = hresp_q;
    assign hrdata_o = hrdata_q;

endmodule

// File: tb/tb_ahb_sram_ws.sv
// Directed bench for ahb_sram_ws: four instances with different widths and
// wait-state settings share one AHB bus; hready_in is the AND of all slaves.
module tb_ahb_sram_ws;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] haddr;
    logic [63:0] hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [3:0]  hsel;
    logic        hrin_blk;
    logic        hready_in;
    logic [3:0]  hrdy;
    logic [3:0]  hrsp;
    logic [31:0] rd0, rd1, rd2;
    logic [63:0] rd3;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign hready_in = hrin_blk ? 1'b0 : (&hrdy);

    ahb_sram_ws #(.ADDR_WIDTH(19), .DATA_WIDTH(32), .MEM_BYTES(32'h1000), .WAIT_STATES(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .haddr_i(haddr), .hwdata_i(hwdata[31:0]), .hrdata_o(rd0),
        .hwrite_i(hwrite), .hsize_i(hsize), .htrans_i(htrans), .hsel_i(hsel[0]),
        .hready_in_i(hready_in), .hready_o(hrdy[0]), .hresp_o(hrsp[0]));

    ahb_sram_ws #(.ADDR_WIDTH(19), .DATA_WIDTH(32), .MEM_BYTES(32'h1000), .WAIT_STATES(3)) u_d1 (
        .clk(clk), .rst_n(rst_n), .haddr_i(haddr), .hwdata_i(hwdata[31:0]), .hrdata_o(rd1),
        .hwrite_i(hwrite), .hsize_i(hsize), .htrans_i(htrans), .hsel_i(hsel[1]),
        .hready_in_i(hready_in), .hready_o(hrdy[1]), .hresp_o(hrsp[1]));

    ahb_sram_ws #(.ADDR_WIDTH(19), .DATA_WIDTH(32), .MEM_BYTES(32'h1000), .WAIT_STATES(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .haddr_i(haddr), .hwdata_i(hwdata[31:0]), .hrdata_o(rd2),
        .hwrite_i(hwrite), .hsize_i(hsize), .htrans_i(htrans), .hsel_i(hsel[2]),
        .hready_in_i(hready_in), .hready_o(hrdy[2]), .hresp_o(hrsp[2]));

    ahb_sram_ws #(.ADDR_WIDTH(19), .DATA_WIDTH(64), .MEM_BYTES(32'h1000), .WAIT_STATES(0)) u_d3 (
        .clk(clk), .rst_n(rst_n), .haddr_i(haddr), .hwdata_i(hwdata), .hrdata_o(rd3),
        .hwrite_i(hwrite), .hsize_i(hsize), .htrans_i(htrans), .hsel_i(hsel[3]),
        .hready_in_i(hready_in), .hready_o(hrdy[3]), .hresp_o(hrsp[3]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rd_of(input int s);
        logic [63:0] v;
        case (s)
            0:       v = {32'd0, rd0};
            1:       v = {32'd0, rd1};
            2:       v = {32'd0, rd2};
            default: v = rd3;
        endcase
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive an address phase; s < 0 deselects every slave.
    task automatic drive(input int s, input logic [31:0] a, input logic w,
                         input logic [2:0] sz, input logic [1:0] tr);
        hsel   = (s < 0) ? 4'd0 : 4'(1 << s);
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        htrans = tr;
    endtask

    // One isolated NONSEQ transfer; returns data/resp sampled at hready=1 and wait count.
    task automatic xfer(input int s, input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [63:0] wd, output logic [63:0] rd, output int waits,
                        output logic resp);
        drive(s, a, w, sz, 2'd2);
        tick();
        drive(-1, 32'd0, 1'b0, 3'd0, 2'd0);
        hwdata = wd;
        waits  = 0;
        while (hrdy[s] !== 1'b1 && waits < 32) begin
            waits++;
            tick();
        end
        if (waits >= 32) chk("ready_timeout", {63'd0, hrdy[s]}, 64'd1);
        rd   = rd_of(s);
        resp = hrsp[s];
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        int          w;
        logic        e;

        // Reset state
        rst_n    = 1'b0;
        hrin_blk = 1'b0;
        hwdata   = 64'd0;
        drive(-1, 32'd0, 1'b0, 3'd0, 2'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hready", {60'd0, hrdy}, 64'hF);
        chk("rst_hresp", {60'd0, hrsp}, 64'h0);
        chk("rst_hrdata0", {32'd0, rd0}, 64'd0);
        chk("rst_hrdata3", rd3, 64'd0);
        rst_n = 1'b1;
        tick();

        // Word write, pipelined byte write to lane 1, pipelined word read (zero waits)
        drive(0, 32'h0, 1'b1, 3'd2, 2'd2);
        tick();
        chk("t2_wr_ready", {63'd0, hrdy[0]}, 64'd1);
        hwdata = 64'h11223344;
        drive(0, 32'h1, 1'b1, 3'd0, 2'd2);
        tick();
        chk("t2_bwr_ready", {63'd0, hrdy[0]}, 64'd1);
        hwdata = 64'h5555AA55;
        drive(0, 32'h0, 1'b0, 3'd2, 2'd2);
        tick();
        chk("t2_rd_ready", {63'd0, hrdy[0]}, 64'd1);
        chk("t2_rd_resp", {63'd0, hrsp[0]}, 64'd0);
        chk("t2_rd_data", {32'd0, rd0}, 64'h1122AA44);
        drive(-1, 32'd0, 1'b0, 3'd0, 2'd0);
        tick();
        chk("t2_idle_hrdata", {32'd0, rd0}, 64'd0);

        // Reset in the middle of a wait-stated write
        xfer(1, 32'h10, 1'b1, 3'd2, 64'hCAFEF00D, r, w, e);
        chk("t1_pre_waits", 64'(w), 64'd3);
        drive(1, 32'h10, 1'b1, 3'd2, 2'd2);
        tick();
        drive(-1, 32'd0, 1'b0, 3'd0, 2'd0);
        hwdata = 64'hDEADBEEF;
        chk("t1_in_wait", {63'd0, hrdy[1]}, 64'd0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_rst_hready", {63'd0, hrdy[1]}, 64'd1);
        chk("t1_rst_hresp", {63'd0, hrsp[1]}, 64'd0);
        chk("t1_rst_hrdata", {32'd0, rd1}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        xfer(1, 32'h10, 1'b0, 3'd2, 64'd0, r, w, e);
        chk("t1_read_data", r, 64'hCAFEF00D);
        chk("t1_read_waits", 64'(w), 64'd3);

        // Two wait states, then a pipelined accept in the DATA cycle
        xfer(2, 32'h8, 1'b1, 3'd2, 64'h0BADF00D, r, w, e);
        chk("t3_wr_waits", 64'(w), 64'd2);
        drive(2, 32'h8, 1'b0, 3'd2, 2'd2);
        tick();
        drive(-1, 32'd0, 1'b0, 3'd0, 2'd0);
        chk("t3_wait1", {63'd0, hrdy[2]}, 64'd0);
        tick();
        chk("t3_wait2", {63'd0, hrdy[2]}, 64'd0);
        tick();
        chk("t3_ready", {63'd0, hrdy[2]}, 64'd1);
        chk("t3_data", {32'd0, rd2}, 64'h0BADF00D);
        drive(2, 32'h8, 1'b0, 3'd2, 2'd3);
        tick();
        drive(-1, 32'd0, 1'b0, 3'd0, 2'd0);
        chk("t3_pipe_wait", {63'd0, hrdy[2]}, 64'd0);
        tick();
        tick();
        chk("t3_pipe_ready", {63'd0, hrdy[2]}, 64'd1);
        chk("t3_pipe_data", {32'd0, rd2}, 64'h0BADF00D);
        tick();
        chk("t3_idle_hrdata", {32'd0, rd2}, 64'd0);

        // Misaligned halfword write -> two-cycle ERROR, pipelined read in ERR2
        drive(0, 32'h3, 1'b1, 3'd1, 2'd2);
        tick();
        drive(-1, 32'd0, 1'b0, 3'd0, 2'd0);
        hwdata = 64'hFFFFFFFF;
        chk("t4_err1_hready", {63'd0, hrdy[0]}, 64'd0);
        chk("t4_err1_hresp", {63'd0, hrsp[0]}, 64'd1);
        tick();
        chk("t4_err2_hready", {63'd0, hrdy[0]}, 64'd1);
        chk("t4_err2_hresp", {63'd0, hrsp[0]}, 64'd1);
        drive(0, 32'h0, 1'b0, 3'd2, 2'd2);
        tick();
        drive(-1, 32'd0, 1'b0, 3'd0, 2'd0);
        chk("t4_rd_hresp", {63'd0, hrsp[0]}, 64'd0);
        chk("t4_rd_hready", {63'd0, hrdy[0]}, 64'd1);
        chk("t4_rd_data", {32'd0, rd0}, 64'h1122AA44);
        tick();

        // Range and size boundaries
        xfer(0, 32'hFFC, 1'b1, 3'd2, 64'h600DCAFE, r, w, e);
        chk("t5_top_wr_resp", {63'd0, e}, 64'd0);
        xfer(0, 32'hFFC, 1'b0, 3'd2, 64'd0, r, w, e);
        chk("t5_top_rd_resp", {63'd0, e}, 64'd0);
        chk("t5_top_rd_data", r, 64'h600DCAFE);
        xfer(0, 32'h1000, 1'b0, 3'd2, 64'd0, r, w, e);
        chk("t5_oob_resp", {63'd0, e}, 64'd1);
        chk("t5_oob_errcycles", 64'(w), 64'd1);
        xfer(0, 32'h0, 1'b0, 3'd3, 64'd0, r, w, e);
        chk("t5_dw32_size3_resp", {63'd0, e}, 64'd1);
        xfer(3, 32'h8, 1'b1, 3'd3, 64'h0123456789ABCDEF, r, w, e);
        chk("t5_dw64_wr_resp", {63'd0, e}, 64'd0);
        xfer(3, 32'h8, 1'b0, 3'd3, 64'd0, r, w, e);
        chk("t5_dw64_rd_resp", {63'd0, e}, 64'd0);
        chk("t5_dw64_rd_data", r, 64'h0123456789ABCDEF);
        xfer(3, 32'hD, 1'b1, 3'd0, 64'hAAAA77AAAAAAAAAA, r, w, e);
        xfer(3, 32'h8, 1'b0, 3'd3, 64'd0, r, w, e);
        chk("t5_dw64_lane5", r, 64'h0123776789ABCDEF);

        // Non-accepted address phases
        hwdata = 64'hFFFFFFFF;
        drive(0, 32'h0, 1'b1, 3'd2, 2'd1);
        tick();
        chk("t6_busy_hready", {63'd0, hrdy[0]}, 64'd1);
        chk("t6_busy_hresp", {63'd0, hrsp[0]}, 64'd0);
        drive(-1, 32'h0, 1'b1, 3'd2, 2'd2);
        tick();
        chk("t6_nosel_hready", {63'd0, hrdy[0]}, 64'd1);
        chk("t6_nosel_hrdata", {32'd0, rd0}, 64'd0);
        hrin_blk = 1'b1;
        drive(0, 32'h0, 1'b1, 3'd2, 2'd2);
        tick();
        chk("t6_nordy_hready", {63'd0, hrdy[0]}, 64'd1);
        chk("t6_nordy_hresp", {63'd0, hrsp[0]}, 64'd0);
        hrin_blk = 1'b0;
        drive(-1, 32'd0, 1'b0, 3'd0, 2'd0);
        tick();
        xfer(0, 32'h0, 1'b0, 3'd2, 64'd0, r, w, e);
        chk("t6_no_write", r, 64'h1122AA44);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
